instr_fetch_unit: RTL and testbench

Initiator side of the instruction-memory interface. Generates word-aligned fetch addresses from an internal PC and issues them over a valid/ready request channel. Collects in-order responses into a small queue and presents {pc, instr} to decode over a valid/ready channel. Handles control-flow redirects by flushing the queue and discarding stale in-flight responses.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue.sv | 52 +++++
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, widths and the
// {pc, instr} queue entry.
package fetch_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        FLUSH
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with push/pop/flush and occupancy count; DEPTH must be a power of 2.
// Head is read straight from storage, so a pushed word is visible the cycle after the push.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator. States: BOOT | idle cycle after reset; FETCH | issue and collect;
// FLUSH | drop stale responses after a redirect. FETCH_ALIGN_CHECK_EN adds sticky fetch_misaligned.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_misaligned
`endif
);
    localparam int CW = $clog2(QDEPTH) + 1;

    state_t          state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [CW-1:0]   discard, discard_next;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   q_count;
    logic [CW:0]     in_flight;
    logic [XLEN-1:0] rsp_addr;
    entry_t          q_in, q_head;
    logic            q_full, q_empty, trk_full, trk_empty;
    logic            redirect_taken, rsp_fire, rsp_keep, rsp_drop;
    logic            req_fire, q_push, q_pop;

    assign redirect_taken = redirect_valid && (state != BOOT);
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_fire  = imem_rsp_valid && !trk_empty;
    assign rsp_keep  = rsp_fire && (state == FETCH) && (discard == '0);
    assign rsp_drop  = rsp_fire && !rsp_keep;
    assign in_flight = {1'b0, outstanding} + {1'b0, q_count};

    assign imem_req_valid = (state == FETCH) && !redirect_valid && !q_full && !trk_full
                            && (in_flight < (CW+1)'(QDEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign q_in   = '{pc: rsp_addr, instr: imem_rsp_data};
    assign q_push = rsp_keep && !redirect_taken;
    assign q_pop  = !q_empty && out_ready && !redirect_taken;

    assign out_valid = !q_empty;
    assign out_pc    = q_empty ? '0 : q_head.pc;
    assign out_instr = q_empty ? '0 : q_head.instr;

    fetch_queue #(.DEPTH(QDEPTH), .WIDTH(XLEN)) u_addr_trk (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_fire),
        .flush     (1'b0),
        .head      (rsp_addr),
        .count     (outstanding),
        .full      (trk_full),
        .empty     (trk_empty)
    );

    fetch_queue #(.DEPTH(QDEPTH), .WIDTH($bits(entry_t))) u_instr_q (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .flush     (redirect_taken),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            discard <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            discard <= discard_next;
        end
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        discard_next = discard;
        if (req_fire) pc_next = pc + XLEN'(INSTR_BYTES);
        if (rsp_drop && discard != '0) discard_next = discard - CW'(1);
        unique case (state)
            BOOT: state_next = FETCH;
            FETCH, FLUSH: begin
                // Every response still owed, less one arriving now, belongs to the old stream.
                if (redirect_taken) begin
                    pc_next      = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
                    discard_next = outstanding - CW'(rsp_fire);
                end
                state_next = (discard_next != '0) ? FLUSH : FETCH;
            end
            default: state_next = BOOT;
        endcase
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fetch_misaligned <= 1'b0;
        else if (redirect_taken && redirect_pc[1:0] != 2'b00)
            fetch_misaligned <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed vector bench for instr_fetch_unit: a per-cycle table of stimulus and expected
// outputs, followed by hand-written sequences for wrap, protocol violation, flush and backpressure.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rv;
        logic [31:0] rd;
        logic        rr;
        logic        ordy;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_in;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic logic [31:0] dat(input logic [31:0] a);
        return 32'hC0DE_0000 + a;
    endfunction

    function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic rv,
                                input logic [31:0] rd, input logic rr, input logic ordy,
                                input logic e_rv, input logic [31:0] e_addr, input logic e_ov,
                                input logic [31:0] e_pc, input logic [31:0] e_in);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.rv = rv; v.rd = rd; v.rr = rr; v.ordy = ordy;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc; v.e_in = e_in;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic redir, input logic [31:0] rpc, input logic rv,
                         input logic [31:0] rd, input logic rr, input logic ordy);
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        imem_req_ready = rr;
        out_ready      = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          nreq;
        logic        pend;
        logic [31:0] paddr;

        //             redir rpc          rv rd               rr ordy | rv addr         ov pc       instr
        vecs[0]  = mk(0, 0,            0, 0,              1, 1,   0, 32'h000, 0, 0,       0);
        vecs[1]  = mk(0, 0,            0, 0,              1, 1,   1, 32'h000, 0, 0,       0);
        vecs[2]  = mk(0, 0,            1, dat(32'h000),   1, 1,   1, 32'h004, 0, 0,       0);
        vecs[3]  = mk(0, 0,            1, dat(32'h004),   1, 1,   0, 32'h008, 1, 32'h000, dat(32'h000));
        vecs[4]  = mk(0, 0,            0, 0,              1, 1,   1, 32'h008, 1, 32'h004, dat(32'h004));
        vecs[5]  = mk(0, 0,            1, dat(32'h008),   1, 1,   1, 32'h00C, 0, 0,       0);
        vecs[6]  = mk(0, 0,            1, dat(32'h00C),   1, 1,   0, 32'h010, 1, 32'h008, dat(32'h008));
        vecs[7]  = mk(0, 0,            0, 0,              1, 0,   1, 32'h010, 1, 32'h00C, dat(32'h00C));
        vecs[8]  = mk(0, 0,            1, dat(32'h010),   1, 0,   0, 32'h014, 1, 32'h00C, dat(32'h00C));
        vecs[9]  = mk(0, 0,            0, 0,              1, 1,   0, 32'h014, 1, 32'h00C, dat(32'h00C));
        vecs[10] = mk(0, 0,            0, 0,              1, 0,   1, 32'h014, 1, 32'h010, dat(32'h010));
        vecs[11] = mk(0, 0,            1, dat(32'h014),   1, 0,   0, 32'h018, 1, 32'h010, dat(32'h010));
        vecs[12] = mk(1, 32'h200,      0, 0,              1, 1,   0, 32'h018, 1, 32'h010, dat(32'h010));
        vecs[13] = mk(0, 0,            0, 0,              1, 1,   1, 32'h200, 0, 0,       0);
        vecs[14] = mk(0, 0,            0, 0,              1, 1,   1, 32'h204, 0, 0,       0);
        vecs[15] = mk(1, 32'h103,      0, 0,              1, 1,   0, 32'h208, 0, 0,       0);
        vecs[16] = mk(0, 0,            1, dat(32'h200),   1, 1,   0, 32'h100, 0, 0,       0);
        vecs[17] = mk(0, 0,            1, dat(32'h204),   1, 1,   0, 32'h100, 0, 0,       0);
        vecs[18] = mk(0, 0,            0, 0,              1, 1,   1, 32'h100, 0, 0,       0);
        vecs[19] = mk(0, 0,            1, dat(32'h100),   0, 1,   1, 32'h104, 0, 0,       0);
        vecs[20] = mk(0, 0,            0, 0,              0, 1,   1, 32'h104, 1, 32'h100, dat(32'h100));
        vecs[21] = mk(0, 0,            0, 0,              1, 1,   1, 32'h104, 0, 0,       0);
        vecs[22] = mk(0, 0,            0, 0,              1, 1,   1, 32'h108, 0, 0,       0);
        vecs[23] = mk(1, 32'h300,      1, dat(32'h104),   1, 1,   0, 32'h10C, 0, 0,       0);
        vecs[24] = mk(0, 0,            1, dat(32'h108),   1, 1,   0, 32'h300, 0, 0,       0);
        vecs[25] = mk(0, 0,            0, 0,              0, 1,   1, 32'h300, 0, 0,       0);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_valid", {31'b0, imem_req_valid}, 0);
        chk("reset_req_addr",  imem_req_addr, 32'h0);
        chk("reset_out_valid", {31'b0, out_valid}, 0);
        chk("reset_out_pc",    out_pc, 0);
        chk("reset_out_instr", out_instr, 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].redir, vecs[i].rpc, vecs[i].rv, vecs[i].rd, vecs[i].rr, vecs[i].ordy);
            #1;
            chk($sformatf("row%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].e_rv});
            chk($sformatf("row%0d_req_addr", i),  imem_req_addr, vecs[i].e_addr);
            chk($sformatf("row%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
            chk($sformatf("row%0d_out_pc", i),    out_pc, vecs[i].e_pc);
            chk($sformatf("row%0d_out_instr", i), out_instr, vecs[i].e_in);
            step();
        end
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misaligned_sticky", {31'b0, fetch_misaligned}, 1);
`endif

        // PC wrap at the top of the address space
        drive(1, 32'hFFFF_FFFC, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 1, 1);
        #1;
        chk("wrap_req_valid", {31'b0, imem_req_valid}, 1);
        chk("wrap_req_addr",  imem_req_addr, 32'hFFFF_FFFC);
        step();
        drive(0, 0, 1, 32'hDEAD_BEEF, 0, 1);
        #1;
        chk("wrap_next_addr", imem_req_addr, 32'h0);
        step();
        drive(0, 0, 0, 0, 0, 1);
        #1;
        chk("wrap_out_pc",    out_pc, 32'hFFFF_FFFC);
        chk("wrap_out_instr", out_instr, 32'hDEAD_BEEF);
        step();

        // Response with nothing outstanding must be ignored without underflow
        drive(0, 0, 1, 32'h1234_5678, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 1);
        #1;
        chk("spurious_out_valid", {31'b0, out_valid}, 0);
        chk("spurious_req_valid", {31'b0, imem_req_valid}, 1);
        chk("spurious_req_addr",  imem_req_addr, 32'h0);

        // Redirect while already flushing keeps the remaining discard count
        drive(0, 0, 0, 0, 1, 1);
        step();
        step();
        drive(1, 32'h400, 0, 0, 0, 1);
        step();
        drive(1, 32'h500, 1, 32'hBAD0_0000, 0, 1);
        #1;
        chk("reflush_req_valid", {31'b0, imem_req_valid}, 0);
        chk("reflush_addr1",     imem_req_addr, 32'h400);
        step();
        drive(0, 0, 1, 32'hBAD0_0004, 0, 1);
        #1;
        chk("reflush_addr2",     imem_req_addr, 32'h500);
        chk("reflush_out_valid", {31'b0, out_valid}, 0);
        step();
        drive(0, 0, 0, 0, 0, 1);
        #1;
        chk("reflush_resume_valid", {31'b0, imem_req_valid}, 1);
        chk("reflush_resume_addr",  imem_req_addr, 32'h500);
        chk("reflush_no_stale_out", {31'b0, out_valid}, 0);

        // Asynchronous reset, then backpressure from decode
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_addr",      imem_req_addr, 32'h0);
        chk("async_rst_out_valid", {31'b0, out_valid}, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misaligned_cleared", {31'b0, fetch_misaligned}, 0);
`endif
        step();
        step();
        rst   = 1'b0;
        nreq  = 0;
        pend  = 1'b0;
        paddr = '0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, pend, dat(paddr), 1, 0);
            #1;
            if (imem_req_valid) nreq++;
            pend  = imem_req_valid;
            paddr = imem_req_addr;
            step();
        end
        chk("bp_request_count", nreq, 2);
        drive(0, 0, 0, 0, 1, 1);
        #1;
        chk("bp_head_pc",          out_pc, 32'h0);
        chk("bp_head_instr",       out_instr, dat(32'h0));
        chk("bp_no_req_on_pop",    {31'b0, imem_req_valid}, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("bp_second_pc",        out_pc, 32'h4);
        chk("bp_second_instr",     out_instr, dat(32'h4));
        chk("bp_req_after_pop",    {31'b0, imem_req_valid}, 1);
        chk("bp_req_addr",         imem_req_addr, 32'h8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
